// File: rtl/calendar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calendar_pkg
//  Description : Shared encodings, reset values and month-length helper for
//                the calendar counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package calendar_pkg;

    localparam logic [1:0] SEL_DATE  = 2'd0;
    localparam logic [1:0] SEL_MONTH = 2'd1;
    localparam logic [1:0] SEL_YEAR  = 2'd2;
    localparam logic [1:0] SEL_RSVD  = 2'd3;

    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] DEC = 4'd12;

    localparam logic [4:0] DATE_RST  = 5'd1;
    localparam logic [3:0] MONTH_RST = 4'd1;

    // Out-of-range months report 31 so callers never see a zero length.
    function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
        logic [4:0] len;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = leap ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calendar_counter_days_in_month.sv
`default_nettype none
// ============================================================================
//  Module      : days_in_month
//  Description : Combinational days-in-month lookup with leap and fixed-length
//                options.
//  Revision    : 1.0 - initial release
// ============================================================================
module days_in_month
    import calendar_pkg::*;
#(
    parameter int LEAP_EN          = 1,
    parameter int FIXED_MONTH_DAYS = 0
) (
    input  logic [3:0] month,
    input  logic [1:0] year_lo,
    output logic [4:0] dim
);

    localparam logic [4:0] c_fixed = 5'(FIXED_MONTH_DAYS);

    logic w_leap;

    assign w_leap = (LEAP_EN != 0) && (year_lo == 2'd0);
    assign dim    = (FIXED_MONTH_DAYS != 0) ? c_fixed : month_len(month, w_leap);

endmodule
`default_nettype wire

// File: rtl/calendar_counter.sv
`default_nettype none
// ============================================================================
//  Module      : calendar_counter
//  Description : Day/month/year counter with leap years, range-checked field
//                loads, rollover pulses and a gated read-back bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module calendar_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W           = 7,
    parameter int YEAR_MAX         = 99,
    parameter int LEAP_EN          = 1,
    parameter int FIXED_MONTH_DAYS = 0,
    parameter int BUS_W            = 7
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              dayCount,
    input  logic              load,
    input  logic [1:0]        load_sel,
    input  logic [BUS_W-1:0]  data,
    input  logic              enable,
    output logic [4:0]        date,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [BUS_W-1:0]  databus,
    output logic              dateCount,
    output logic              yearCount,
    output logic              load_err
);

    localparam logic [YEAR_W-1:0] c_year_max = YEAR_W'(YEAR_MAX);

    logic [4:0]        r_date;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic              r_date_pulse;
    logic              r_year_pulse;
    logic              r_load_err;

    logic [4:0]        w_date_nxt;
    logic [3:0]        w_month_nxt;
    logic [YEAR_W-1:0] w_year_nxt;
    logic              w_date_pulse_nxt;
    logic              w_year_pulse_nxt;
    logic              w_load_err_nxt;

    logic [4:0]        w_dim_cur;
    logic [4:0]        w_dim_tgt;
    logic [3:0]        w_tgt_month;
    logic [YEAR_W-1:0] w_tgt_year;
    logic [4:0]        w_clamped;
    logic [31:0]       w_data32;
    logic              w_load_ok;
    logic              w_bad;

    // Target month/year is what the calendar would look like after this load.
    assign w_tgt_month = (load_sel == SEL_MONTH) ? data[3:0] : r_month;
    assign w_tgt_year  = (load_sel == SEL_YEAR) ? data[YEAR_W-1:0] : r_year;

    days_in_month #(
        .LEAP_EN          (LEAP_EN),
        .FIXED_MONTH_DAYS (FIXED_MONTH_DAYS)
    ) u_dim_cur (
        .month   (r_month),
        .year_lo (r_year[1:0]),
        .dim     (w_dim_cur)
    );

    days_in_month #(
        .LEAP_EN          (LEAP_EN),
        .FIXED_MONTH_DAYS (FIXED_MONTH_DAYS)
    ) u_dim_tgt (
        .month   (w_tgt_month),
        .year_lo (w_tgt_year[1:0]),
        .dim     (w_dim_tgt)
    );

    // Full-width compares also reject any nonzero bits above the field width.
    assign w_data32  = 32'(data);
    assign w_clamped = (r_date > w_dim_tgt) ? w_dim_tgt : r_date;
    assign w_bad     = (r_date == 5'd0) || (r_date > w_dim_cur) ||
                       (r_month == 4'd0) || (r_month > DEC);

    always_comb begin
        w_load_ok = 1'b0;
        case (load_sel)
            SEL_DATE:  w_load_ok = (w_data32 >= 32'd1) && (w_data32 <= 32'(w_dim_tgt));
            SEL_MONTH: w_load_ok = (w_data32 >= 32'd1) && (w_data32 <= 32'(DEC));
            SEL_YEAR:  w_load_ok = (w_data32 <= 32'(c_year_max));
            default:   w_load_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_date_nxt       = r_date;
        w_month_nxt      = r_month;
        w_year_nxt       = r_year;
        w_date_pulse_nxt = 1'b0;
        w_year_pulse_nxt = 1'b0;
        w_load_err_nxt   = 1'b0;
        if (w_bad) begin
            w_date_nxt  = DATE_RST;
            w_month_nxt = MONTH_RST;
        end else if (load) begin
            if (!w_load_ok) begin
                w_load_err_nxt = 1'b1;
            end else begin
                case (load_sel)
                    SEL_DATE: w_date_nxt = data[4:0];
                    SEL_MONTH: begin
                        w_month_nxt = data[3:0];
                        w_date_nxt  = w_clamped;
                    end
                    SEL_YEAR: begin
                        w_year_nxt = data[YEAR_W-1:0];
                        w_date_nxt = w_clamped;
                    end
                    default: ;
                endcase
            end
        end else if (dayCount) begin
            if (r_date < w_dim_cur) begin
                w_date_nxt = r_date + 5'd1;
            end else begin
                w_date_nxt       = DATE_RST;
                w_date_pulse_nxt = 1'b1;
                if (r_month == DEC) begin
                    w_month_nxt      = MONTH_RST;
                    w_year_pulse_nxt = 1'b1;
                    w_year_nxt       = (r_year == c_year_max) ? '0 : r_year + YEAR_W'(1);
                end else begin
                    w_month_nxt = r_month + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_date       <= DATE_RST;
            r_month      <= MONTH_RST;
            r_year       <= '0;
            r_date_pulse <= 1'b0;
            r_year_pulse <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_date       <= w_date_nxt;
            r_month      <= w_month_nxt;
            r_year       <= w_year_nxt;
            r_date_pulse <= w_date_pulse_nxt;
            r_year_pulse <= w_year_pulse_nxt;
            r_load_err   <= w_load_err_nxt;
        end
    end

    always_comb begin
        databus = '0;
        if (enable) begin
            case (load_sel)
                SEL_DATE:  databus = BUS_W'(r_date);
                SEL_MONTH: databus = BUS_W'(r_month);
                SEL_YEAR:  databus = BUS_W'(r_year);
                default:   databus = '0;
            endcase
        end
    end

    assign date      = r_date;
    assign month     = r_month;
    assign year      = r_year;
    assign dateCount = r_date_pulse;
    assign yearCount = r_year_pulse;
    assign load_err  = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_calendar_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calendar_counter
//  Description : Scoreboard bench for calendar_counter: default, no-leap and
//                fixed-30-day instances driven by directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calendar_counter;

    localparam int N = 3;

    typedef struct {
        int    tag;
        int    id;
        int    d;
        int    m;
        int    y;
        int    dc;
        int    yc;
        int    er;
        string nm;
    } exp_t;

    logic       clk;
    logic       clear;
    logic       day_i [N];
    logic       ld_i  [N];
    logic [1:0] sel_i [N];
    logic [6:0] dat_i [N];
    logic       en_i  [N];
    logic [4:0] date_o [N];
    logic [3:0] month_o [N];
    logic [6:0] year_o [N];
    logic [6:0] bus_o [N];
    logic       dc_o [N];
    logic       yc_o [N];
    logic       er_o [N];

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;
    int   cur_m [N];
    int   cur_y [N];

    calendar_counter dut0 (
        .clk(clk), .clear(clear), .dayCount(day_i[0]), .load(ld_i[0]),
        .load_sel(sel_i[0]), .data(dat_i[0]), .enable(en_i[0]),
        .date(date_o[0]), .month(month_o[0]), .year(year_o[0]), .databus(bus_o[0]),
        .dateCount(dc_o[0]), .yearCount(yc_o[0]), .load_err(er_o[0])
    );

    calendar_counter #(.LEAP_EN(0)) dut1 (
        .clk(clk), .clear(clear), .dayCount(day_i[1]), .load(ld_i[1]),
        .load_sel(sel_i[1]), .data(dat_i[1]), .enable(en_i[1]),
        .date(date_o[1]), .month(month_o[1]), .year(year_o[1]), .databus(bus_o[1]),
        .dateCount(dc_o[1]), .yearCount(yc_o[1]), .load_err(er_o[1])
    );

    calendar_counter #(.FIXED_MONTH_DAYS(30)) dut2 (
        .clk(clk), .clear(clear), .dayCount(day_i[2]), .load(ld_i[2]),
        .load_sel(sel_i[2]), .data(dat_i[2]), .enable(en_i[2]),
        .date(date_o[2]), .month(month_o[2]), .year(year_o[2]), .databus(bus_o[2]),
        .dateCount(dc_o[2]), .yearCount(yc_o[2]), .load_err(er_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            day_i[i] = 1'b0;
            ld_i[i]  = 1'b0;
            sel_i[i] = 2'd0;
            dat_i[i] = 7'd0;
            en_i[i]  = 1'b0;
        end
    endtask

    // One clock of stimulus on instance id; expectation applies after the next edge.
    task automatic step(input int id, input bit day, input bit ld, input int s, input int dv,
                        input int ed, input int em, input int ey,
                        input int edc, input int eyc, input int eer, input string nm);
        exp_t e;
        idle_all();
        day_i[id] = day;
        ld_i[id]  = ld;
        sel_i[id] = 2'(s);
        dat_i[id] = 7'(dv);
        e.tag = cyc + 1; e.id = id; e.d = ed; e.m = em; e.y = ey;
        e.dc = edc; e.yc = eyc; e.er = eer; e.nm = nm;
        sb.push_back(e);
        cur_m[id] = em;
        cur_y[id] = ey;
        @(negedge clk);
    endtask

    // Walks a counter to y/m/d through legal loads: date 1 first so no clamp interferes.
    task automatic set(input int id, input int y, input int m, input int d);
        step(id, 0, 1, 0, 1, 1, cur_m[id], cur_y[id], 0, 0, 0, "set_d1");
        step(id, 0, 1, 2, y, 1, cur_m[id], y, 0, 0, 0, "set_y");
        step(id, 0, 1, 1, m, 1, m, y, 0, 0, 0, "set_m");
        step(id, 0, 1, 0, d, d, m, y, 0, 0, 0, "set_d");
    endtask

    task automatic bus_chk(input bit en, input int s, input int exp, input string nm);
        idle_all();
        en_i[0]  = en;
        sel_i[0] = 2'(s);
        #1;
        cmp(nm, int'(bus_o[0]), exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                cmp({e.nm, "_date"},  int'(date_o[e.id]),  e.d);
                cmp({e.nm, "_month"}, int'(month_o[e.id]), e.m);
                cmp({e.nm, "_year"},  int'(year_o[e.id]),  e.y);
                cmp({e.nm, "_dc"},    int'(dc_o[e.id]),    e.dc);
                cmp({e.nm, "_yc"},    int'(yc_o[e.id]),    e.yc);
                cmp({e.nm, "_err"},   int'(er_o[e.id]),    e.er);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int waited;
        cyc = 0; checks = 0; errors = 0;
        for (int i = 0; i < N; i++) begin cur_m[i] = 1; cur_y[i] = 0; end
        idle_all();
        clear = 1'b0;
        #1 clear = 1'b1;
        #1;
        cmp("rst_date", int'(date_o[0]), 1);
        cmp("rst_month", int'(month_o[0]), 1);
        cmp("rst_year", int'(year_o[0]), 0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;

        // Async clear mid-count, checked before any clock edge.
        set(0, 3, 5, 16);
        step(0, 1, 0, 0, 0, 17, 5, 3, 0, 0, 0, "cnt17");
        #2 clear = 1'b1;
        #1;
        cmp("aclr_date", int'(date_o[0]), 1);
        cmp("aclr_month", int'(month_o[0]), 1);
        cmp("aclr_year", int'(year_o[0]), 0);
        cmp("aclr_dc", int'(dc_o[0]), 0);
        idle_all();
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < N; i++) begin cur_m[i] = 1; cur_y[i] = 0; end
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "post_clr");

        // Month lengths
        set(0, 0, 1, 31);
        step(0, 1, 0, 0, 0, 1, 2, 0, 1, 0, 0, "jan31");
        step(0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, "jan31_pulse_end");
        set(0, 0, 4, 30);
        step(0, 1, 0, 0, 0, 1, 5, 0, 1, 0, 0, "apr30");

        // Leap year handling
        set(0, 24, 2, 28);
        step(0, 1, 0, 0, 0, 29, 2, 24, 0, 0, 0, "leap28");
        step(0, 1, 0, 0, 0, 1, 3, 24, 1, 0, 0, "leap29");
        set(0, 23, 2, 28);
        step(0, 1, 0, 0, 0, 1, 3, 23, 1, 0, 0, "noleap28");
        set(1, 24, 2, 28);
        step(1, 1, 0, 0, 0, 1, 3, 24, 1, 0, 0, "leapdis28");

        // Year increment and wrap
        set(0, 5, 12, 31);
        step(0, 1, 0, 0, 0, 1, 1, 6, 1, 1, 0, "dec31");
        set(0, 99, 12, 31);
        step(0, 1, 0, 0, 0, 1, 1, 0, 1, 1, 0, "wrap99");
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, "wrap_pulse_end");

        // Back-to-back day pulses
        set(0, 0, 1, 30);
        step(0, 1, 0, 0, 0, 31, 1, 0, 0, 0, 0, "b2b_1");
        step(0, 1, 0, 0, 0, 1, 2, 0, 1, 0, 0, "b2b_2");
        step(0, 1, 0, 0, 0, 2, 2, 0, 0, 0, 0, "b2b_3");

        // Rejected loads
        set(0, 0, 4, 15);
        step(0, 0, 1, 0, 31, 15, 4, 0, 0, 0, 1, "ld_apr31");
        step(0, 0, 0, 0, 0, 15, 4, 0, 0, 0, 0, "err_pulse_end");
        step(0, 0, 1, 0, 0, 15, 4, 0, 0, 0, 1, "ld_date0");
        step(0, 0, 1, 1, 13, 15, 4, 0, 0, 0, 1, "ld_month13");
        step(0, 0, 1, 1, 7'h42, 15, 4, 0, 0, 0, 1, "ld_month_hibits");
        step(0, 0, 1, 2, 100, 15, 4, 0, 0, 0, 1, "ld_year100");
        step(0, 0, 1, 3, 1, 15, 4, 0, 0, 0, 1, "ld_rsvd");
        step(0, 1, 1, 1, 0, 15, 4, 0, 0, 0, 1, "ld_bad_with_day");

        // Clamping on month/year load
        set(0, 23, 1, 31);
        step(0, 0, 1, 1, 2, 28, 2, 23, 0, 0, 0, "clamp_month");
        set(0, 24, 2, 29);
        step(0, 0, 1, 2, 23, 28, 2, 23, 0, 0, 0, "clamp_year");
        set(0, 0, 3, 31);
        step(0, 0, 1, 1, 6, 30, 6, 0, 0, 0, 0, "clamp_jun");

        // Load wins over dayCount
        set(0, 0, 3, 31);
        step(0, 1, 1, 0, 20, 20, 3, 0, 0, 0, 0, "ld_over_day");

        // Fixed 30-day mode
        set(2, 0, 1, 30);
        step(2, 1, 0, 0, 0, 1, 2, 0, 1, 0, 0, "fix_jan30");
        set(2, 0, 2, 30);
        step(2, 1, 0, 0, 0, 1, 3, 0, 1, 0, 0, "fix_feb30");
        step(2, 0, 1, 0, 31, 1, 3, 0, 0, 0, 1, "fix_ld31");

        // Read-back bus
        set(0, 42, 7, 9);
        bus_chk(1, 2, 42, "bus_year");
        bus_chk(0, 2, 0, "bus_off");
        bus_chk(1, 0, 9, "bus_date");
        bus_chk(1, 1, 7, "bus_month");
        bus_chk(1, 3, 0, "bus_rsvd");
        idle_all();

        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d expected=0 pending", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calendar_counter.md
Name: calendar_counter

Overview:
Parametrised day/month/year calendar counter. It advances one day on each dayCount pulse from the time-of-day chain, applies real month lengths and the leap-year rule, and emits month and year rollover pulses. It supports per-field load with range checking, and provides a gated read-back bus for the display/host mux. It supersedes the fixed 30-day date counter; that behaviour stays available through FIXED_MONTH_DAYS.

Parameters:
YEAR_W, 7, width of year field (year offset from 2000)
YEAR_MAX, 99, last valid year offset; must be ≤ 2^YEAR_W-1
LEAP_EN, 1, 1 = February has 29 days when year%4==0; 0 = February always 28
FIXED_MONTH_DAYS, 0, 0 = real month lengths; 1..31 = every month has this length (30 = legacy mode)
BUS_W, 7, width of data/databus; must be ≥ max(5, YEAR_W)

Ports:
clk  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
dayCount  input  1  one-cycle pulse: advance one day
load  input  1  write data into the field chosen by load_sel this cycle
load_sel  input  2  field select for load and read-back: 0 date, 1 month, 2 year, 3 reserved
data  input  BUS_W  load value (binary)
enable  input  1  databus output enable
date  output  5  day of month, 1..31
month  output  4  month, 1..12
year  output  YEAR_W  year offset, 0..YEAR_MAX
databus  output  BUS_W  read-back of the selected field, zero-extended
dateCount  output  1  registered one-cycle pulse, month rolled over
yearCount  output  1  registered one-cycle pulse, year rolled over
load_err  output  1  registered one-cycle pulse, load rejected

Behaviour:
- Reset (clear high, async): date=1, month=1, year=0, dateCount=yearCount=load_err=0. Counting resumes on the first clk edge after clear falls.
- dim = days in current month: Jan/Mar/May/Jul/Aug/Oct/Dec 31; Apr/Jun/Sep/Nov 30; Feb 28, or 29 if LEAP_EN and year[1:0]==0. If FIXED_MONTH_DAYS≠0, dim = FIXED_MONTH_DAYS for all months.
- Day advance (dayCount=1, load=0) updates at the same clk edge:
  - date<dim: date+1.
  - date==dim: date=1, month+1, dateCount=1 next cycle.
  - month==12 and date==dim: month=1, year+1, yearCount=1 (dateCount also 1).
  - year==YEAR_MAX at year rollover: year=0. yearCount still pulses.
- Pulses last exactly one cycle. Back-to-back dayCount on consecutive cycles is legal; each cycle advances one day.
- Load (load=1) has priority over dayCount. dayCount in the same cycle is dropped, with no advance and no pulses.
  - sel 0: accepted if 1≤data≤dim of the current month/year.
  - sel 1: accepted if 1≤data≤12. If date > dim of the new month (current year), date clamps to that dim in the same edge.
  - sel 2: accepted if data≤YEAR_MAX. If month==2 and date > new Feb dim, date clamps to 28.
  - sel 3: always rejected.
  - Rejected load: no state change, load_err=1 next cycle.
  - Upper data bits beyond the field width must be zero, otherwise the load is rejected.
- databus is combinational: enable ? zero-extended field(load_sel) : 0. sel 3 reads 0. No registered latency.
- No illegal state is reachable. Out-of-range state, defensively: date>dim or month∉1..12 forces date=1, month=1 on the next edge.

Decomposition:
- Package calendar_pkg:
  - load_sel encodings SEL_DATE/SEL_MONTH/SEL_YEAR/SEL_RSVD.
  - Month constants FEB=2, DEC=12.
  - Reset values DATE_RST=1, MONTH_RST=1.
  - Function month_len(month, leap) returning 5-bit days.
- Sub-module days_in_month: combinational; inputs month, year[1:0], params LEAP_EN/FIXED_MONTH_DAYS; output dim.
- It is instantiated twice: once for current state, once for the load target (new month/year) used in clamping and validation.

Test Plan:
- Reset: assert clear mid-count with date=17, month=5 -> outputs immediately 1/1/0 and all pulses 0, without waiting for clk.
- Month lengths: month=1, date=31, dayCount -> date=1, month=2, dateCount for one cycle. Repeat with month=4, date=30 -> month=5.
- Leap: year=24, month=2, date=28, dayCount -> date=29. A second dayCount -> 3/1. With year=23 from 2/28 -> 3/1. With LEAP_EN=0, year=24 -> 3/1.
- Year wrap: year=99, 12/31, dayCount -> 1/1/0, with dateCount and yearCount both pulsed in the same cycle.
- Load: month=4, load date 31 -> load_err, date unchanged.
  - date=31, month=1, load month 2 at year 23 -> month=2, date=28.
  - load and dayCount in the same cycle -> only the load takes effect.
- Legacy/bus: FIXED_MONTH_DAYS=30 -> 30 -> 1 with dateCount in every month. enable=0 -> databus=0. enable=1, load_sel=2, year=42 -> databus=42.
